// File: rtl/lfsr_2_step_search.sv
// Receive-side checker: re-runs the lfsr_2 step from a seed until the target is hit.
// Optional macro LFSR_SEARCH_ZERO_ABORT_EN ends the search early once cur reaches 0.
module lfsr_2_step_search #(
    parameter int unsigned MAX_STEPS = 255,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       seed_i,
    input  logic [7:0]       target_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             found_o,
    output logic [CNT_W-1:0] steps_o
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    state_t           state;
    logic [7:0]       cur;
    logic [7:0]       tgt;
    logic [CNT_W-1:0] cnt;
    logic             zero_abort;

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        logic [7:0] n;
        n[0] = 1'b0;
        n[1] = x[0];
        n[2] = x[1];
        n[3] = x[2] ^ x[7];
        n[4] = x[3];
        n[5] = x[4];
        n[6] = x[5] ^ x[7];
        n[7] = x[6] ^ x[7];
        return n;
    endfunction

    // Zero is a fixed point of the step, so a nonzero target can never follow it.
`ifdef LFSR_SEARCH_ZERO_ABORT_EN
    assign zero_abort = (cur == '0) && (tgt != '0);
`else
    assign zero_abort = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cur     <= '0;
            tgt     <= '0;
            cnt     <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            found_o <= 1'b0;
            steps_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        cur     <= seed_i;
                        tgt     <= target_i;
                        cnt     <= '0;
                        found_o <= 1'b0;
                        steps_o <= '0;
                        busy_o  <= 1'b1;
                        state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (cur == tgt) begin
                        found_o <= 1'b1;
                        steps_o <= cnt;
                        done_o  <= 1'b1;
                        state   <= DONE;
                    end else if (cnt == MAX_CNT || zero_abort) begin
                        found_o <= 1'b0;
                        steps_o <= cnt;
                        done_o  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cur <= lfsr_step(cur);
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_2_step_search.sv
// Scoreboard bench for lfsr_2_step_search: expected results queued at start, checked at done_o.
module tb_lfsr_2_step_search;

    localparam int unsigned MAX_STEPS = 255;
    localparam int unsigned CNT_W     = 8;
    localparam int          BUDGET    = 400;

    logic             clk_i;
    logic             rst_i;
    logic [7:0]       seed_i;
    logic [7:0]       target_i;
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic             found_o;
    logic [CNT_W-1:0] steps_o;

    typedef struct {
        logic        found;
        logic [7:0]  steps;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    lfsr_2_step_search #(
        .MAX_STEPS(MAX_STEPS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .seed_i  (seed_i),
        .target_i(target_i),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .found_o (found_o),
        .steps_o (steps_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Multiply-by-x form of the generator polynomial: shift left, fold bit 7 back as 0xC8.
    function automatic logic [7:0] model_step(input logic [7:0] x);
        logic [8:0] w;
        w = {x, 1'b0};
        return w[8] ? (w[7:0] ^ 8'hC8) : w[7:0];
    endfunction

    function automatic exp_t model_search(input logic [7:0] s, input logic [7:0] t);
        exp_t       e;
        logic [7:0] c;
        c = s;
        e.found = 1'b0;
        e.steps = '0;
        for (int unsigned k = 0; k <= MAX_STEPS; k++) begin
            if (c == t) begin
                e.found = 1'b1;
                e.steps = 8'(k);
                break;
            end
            if (k == MAX_STEPS) begin
                e.steps = 8'(k);
                break;
            end
`ifdef LFSR_SEARCH_ZERO_ABORT_EN
            if (c == 8'h00 && t != 8'h00) begin
                e.steps = 8'(k);
                break;
            end
`endif
            c = model_step(c);
        end
        e.lat = int'(e.steps) + 2;
        return e;
    endfunction

    // extra_at: cycle in which a second start (5A/5A) is pulsed; -1 for none.
    task automatic run_search(input string name, input logic [7:0] s, input logic [7:0] t,
                              input int extra_at);
        exp_t e;
        exp_t got_e;
        int   cyc;
        int   ndone;
        int   done_cyc;
        bit   got;
        e = model_search(s, t);
        sb.push_back(e);
        @(negedge clk_i);
        seed_i   = s;
        target_i = t;
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i  = 1'b0;
        cyc      = 1;
        ndone    = 0;
        done_cyc = 0;
        got      = 1'b0;
        check({name, "_busy_c1"}, 32'(busy_o), 32'd1);
        while (cyc < BUDGET) begin
            if (cyc == extra_at) begin
                seed_i   = 8'h5A;
                target_i = 8'h5A;
                start_i  = 1'b1;
            end else begin
                start_i  = 1'b0;
            end
            if (done_o) begin
                ndone++;
                if (!got) begin
                    got_e = sb.pop_front();
                    check({name, "_found"}, 32'(found_o), 32'(got_e.found));
                    check({name, "_steps"}, 32'(steps_o), 32'(got_e.steps));
                    check({name, "_latency"}, 32'(cyc), 32'(got_e.lat));
                    got      = 1'b1;
                    done_cyc = cyc;
                end
            end
            if (got && cyc >= done_cyc + 4) break;
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        if (!got) begin
            check({name, "_timeout"}, 32'(cyc), 32'(e.lat));
            void'(sb.pop_front());
        end
        check({name, "_done_pulses"}, 32'(ndone), 32'd1);
        check({name, "_busy_end"}, 32'(busy_o), 32'd0);
        check({name, "_found_held"}, 32'(found_o), 32'(e.found));
        check({name, "_steps_held"}, 32'(steps_o), 32'(e.steps));
    endtask

    task automatic run_reset_mid(input logic [7:0] s, input logic [7:0] t, input int rst_at);
        int ndone;
        ndone = 0;
        @(negedge clk_i);
        seed_i   = s;
        target_i = t;
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i  = 1'b0;
        for (int c = 1; c < rst_at; c++) begin
            if (done_o) ndone++;
            @(negedge clk_i);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rstmid_busy", 32'(busy_o), 32'd0);
        check("rstmid_found", 32'(found_o), 32'd0);
        check("rstmid_steps", 32'(steps_o), 32'd0);
        for (int c = 0; c < 20; c++) begin
            if (done_o) ndone++;
            @(negedge clk_i);
        end
        check("rstmid_no_done", 32'(ndone), 32'd0);
    endtask

    initial begin
        logic [7:0] rs;
        logic [7:0] rt;
        int         hops;
        rst_i    = 1'b1;
        start_i  = 1'b0;
        seed_i   = '0;
        target_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_found", 32'(found_o), 32'd0);
        check("rst_steps", 32'(steps_o), 32'd0);
        rst_i = 1'b0;

        run_search("t2", 8'h01, 8'hC8, -1);
        run_search("t3a", 8'h01, 8'h58, -1);
        run_search("t3b", 8'h5A, 8'h5A, -1);
        run_search("t4", 8'h01, 8'h03, -1);
        run_search("t5busy", 8'h01, 8'hC8, 3);
        run_search("t5done", 8'h01, 8'hC8, 10);
        run_reset_mid(8'h01, 8'hC8, 5);
        run_search("t6", 8'h01, 8'hC8, -1);

        for (int i = 0; i < 4; i++) begin
            rs   = 8'($urandom_range(1, 255));
            hops = $urandom_range(0, 20);
            rt   = rs;
            for (int h = 0; h < hops; h++) rt = model_step(rt);
            run_search("rnd", rs, rt, -1);
        end
        run_search("zero_seed", 8'h00, 8'h10, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
